mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Bus target for the CPU's memory interface. It decodes MAR/write/MBR_W, returns MBR_R, and holds a word-addressed RAM.
- It also provides a memory-mapped byte-output port: a TX FIFO with a valid/ready drain, used as a console or testbench sink.
- Sits between the CPU and the testbench, replacing a plain memory when program output is required.

Parameters:
- BITS_DATA, 32, data word width
- BITS_ADDR, 16, address width (word addressing)
- RAM_WORDS, 4096, RAM depth; RAM occupies addresses 0..RAM_WORDS-1
- IO_BASE, 16'hFF00, base address of the I/O registers
- FIFO_DEPTH, 8, TX FIFO entries (power of two, >=2)

Ports:
- clk  input  1  clock; all state on posedge, except the read register on negedge
- reset  input  1  asynchronous, active-low reset
- MAR  input  BITS_ADDR  word address from CPU
- MBR_W  input  BITS_DATA  write data from CPU
- write  input  1  1 = write access, 0 = read access
- MBR_R  output  BITS_DATA  read data to CPU
- out_data  output  8  byte at FIFO head
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  sink accepts byte when high together with out_valid

Behaviour:
- Reset (reset=0, async) forces:
  - MBR_R=0, out_valid=0, out_data=0.
  - FIFO pointers and count=0, drop counter=0, write-edge tracker cleared (prev_write=0, prev_MAR=0).
  - RAM contents are not reset.
- Reset mid-operation discards all queued FIFO bytes. Any in-flight write at the asserting edge is lost.
- Address map:
  - 0..RAM_WORDS-1: RAM read/write.
  - IO_BASE+0 TXDATA: write pushes MBR_W[7:0]; read returns 0.
  - IO_BASE+1 STATUS (read-only): bit0=full, bit1=empty, bits[7:4]=count, others 0.
  - IO_BASE+2 DROPS (read-only): zero-extended 16-bit count of bytes dropped on full FIFO.
  - All other addresses: read 0, writes ignored.
- Read timing:
  - MBR_R is registered on negedge clk from the current MAR.
  - A MAR driven at posedge k is therefore valid to the CPU at posedge k+1 (one-cycle read latency).
  - MBR_R is updated every negedge regardless of write.
- Write timing:
  - When write=1, the access commits at posedge clk using MAR and MBR_W.
  - Read-after-write to the same RAM address: the negedge following the committing posedge returns the new data.
- TX push qualification:
  - A push occurs only on a new write access: write=1 and (prev_write=0 or MAR!=prev_MAR) and MAR==IO_BASE.
  - Holding write high on TXDATA for N cycles pushes exactly one byte.
  - RAM writes are not qualified; repeats are harmless.
- FIFO:
  - Circular buffer with read/write pointers of log2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH, and a separate count of log2(FIFO_DEPTH)+1 bits.
  - out_data = entry at the read pointer. out_valid = (count!=0).
  - Pop at posedge when out_valid & out_ready.
  - Push when not full: entry written, count+1.
  - Push when full and no pop: byte dropped; DROPS increments, saturating at 16'hFFFF.
  - Push and pop in the same cycle, count>0 (including full): both occur, count unchanged, no drop.
  - Push into empty FIFO: out_valid rises the cycle after the push edge. No pop possible the same cycle (fall-through not supported).
  - out_data holds its last value when the FIFO is empty.
- STATUS/DROPS reads reflect state after the most recent posedge, sampled at the negedge.

Test Plan:
- RAM round trip: write 32'hDEADBEEF to addr 5, then MAR=5 with write=0 -> MBR_R=32'hDEADBEEF one cycle after MAR is driven. Read of unmapped addr 16'h8000 -> 0.
- TX push/drain: with out_ready=0, write 'A','B','C' to 16'hFF00 -> STATUS=32'h00000030. Raise out_ready -> out_data A,B,C on consecutive cycles; then out_valid=0, STATUS bit1=1.
- Held write: write=1 to 16'hFF00 held 4 cycles with MBR_W=32'h41 -> exactly one FIFO entry, count=1.
- Overflow: out_ready=0, 10 distinct pushes (toggle write) with FIFO_DEPTH=8 -> STATUS bit0=1, count=8, DROPS=2. Drain yields the first 8 bytes in order.
- Simultaneous push/pop when full: full FIFO, out_ready=1 while pushing 'Z' -> count stays 8, DROPS unchanged, 'Z' emerges last.
- Async reset mid-drain: pull reset low between clock edges with 5 queued -> out_valid=0, MBR_R=0 immediately. After release, STATUS=32'h00000002 and DROPS=0; RAM data written before reset still reads back.

Source files
------------

// File: rtl/mem_responder.sv
// CPU-facing memory target: word-addressed RAM plus a memory-mapped TX byte FIFO
// drained over a valid/ready port. MBR_R is captured on the falling clock edge.
module mem_responder #(
    parameter int unsigned          BITS_DATA  = 32,
    parameter int unsigned          BITS_ADDR  = 16,
    parameter int unsigned          RAM_WORDS  = 4096,
    parameter logic [BITS_ADDR-1:0] IO_BASE    = 16'hFF00,
    parameter int unsigned          FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BITS_ADDR-1:0] MAR,
    input  logic [BITS_DATA-1:0] MBR_W,
    input  logic                 write,
    output logic [BITS_DATA-1:0] MBR_R,
    output logic [7:0]           out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int unsigned RAW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int unsigned PW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam logic [BITS_ADDR-1:0] STATUS_ADDR = IO_BASE + BITS_ADDR'(1'b1);
    localparam logic [BITS_ADDR-1:0] DROPS_ADDR  = IO_BASE + BITS_ADDR'(2'd2);
    localparam logic [CW-1:0]        DEPTH_CNT   = CW'(FIFO_DEPTH);

    logic [BITS_DATA-1:0] ram_q [RAM_WORDS];
    logic [7:0]           fifo_q [FIFO_DEPTH];

    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [15:0]          drops_q, drops_d;
    logic                 prev_write_q, prev_write_d;
    logic [BITS_ADDR-1:0] prev_mar_q, prev_mar_d;
    logic [7:0]           out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic [BITS_DATA-1:0] mbr_r_q, mbr_r_d;

    logic                 ram_hit_s;
    logic [RAW-1:0]       ram_idx_s;
    logic                 full_s, empty_s;
    logic                 push_s, pop_s, push_ok_s, drop_s;
    logic [3:0]           cnt4_s;

    // Address decode and FIFO control strobes.
    always_comb begin
        ram_hit_s = (32'(MAR) < RAM_WORDS);
        ram_idx_s = MAR[RAW-1:0];
        full_s    = (count_q == DEPTH_CNT);
        empty_s   = (count_q == {CW{1'b0}});
        cnt4_s    = 4'(count_q);
        // Only a fresh write access (edge or address change) pushes a byte.
        push_s    = write && (!prev_write_q || (MAR != prev_mar_q)) && (MAR == IO_BASE);
        pop_s     = out_valid_q && out_ready;
        push_ok_s = push_s && (!full_s || pop_s);
        drop_s    = push_s && full_s && !pop_s;
    end

    // FIFO pointer, count, drop counter and head-byte next state.
    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        drops_d      = drops_q;
        out_data_d   = out_data_q;
        prev_write_d = write;
        prev_mar_d   = MAR;

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
        endcase

        if (drop_s && (drops_q != 16'hFFFF)) begin
            drops_d = drops_q + 16'd1;
        end else begin
            drops_d = drops_q;
        end

        // The head slot may be the one being written this cycle (push into empty).
        if (count_d == {CW{1'b0}}) begin
            out_data_d = out_data_q;
        end else if (push_ok_s && (wr_ptr_q == rd_ptr_d)) begin
            out_data_d = MBR_W[7:0];
        end else begin
            out_data_d = fifo_q[rd_ptr_d];
        end

        out_valid_d = (count_d != {CW{1'b0}});
    end

    // Read-data mux; sampled by the falling-edge register.
    always_comb begin
        mbr_r_d = {BITS_DATA{1'b0}};
        if (ram_hit_s) begin
            mbr_r_d = ram_q[ram_idx_s];
        end else if (MAR == STATUS_ADDR) begin
            mbr_r_d = {{(BITS_DATA-8){1'b0}}, cnt4_s, 2'b00, empty_s, full_s};
        end else if (MAR == DROPS_ADDR) begin
            mbr_r_d = {{(BITS_DATA-16){1'b0}}, drops_q};
        end else begin
            mbr_r_d = {BITS_DATA{1'b0}};
        end
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (reset && write && ram_hit_s) begin
            ram_q[ram_idx_s] <= MBR_W;
        end
    end

    // FIFO storage; validity is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            fifo_q[wr_ptr_q] <= MBR_W[7:0];
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q     <= {PW{1'b0}};
            wr_ptr_q     <= {PW{1'b0}};
            count_q      <= {CW{1'b0}};
            drops_q      <= 16'h0000;
            prev_write_q <= 1'b0;
            prev_mar_q   <= {BITS_ADDR{1'b0}};
            out_data_q   <= 8'h00;
            out_valid_q  <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            drops_q      <= drops_d;
            prev_write_q <= prev_write_d;
            prev_mar_q   <= prev_mar_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
        end
    end

    // Read data captured on the falling edge: one-cycle read latency.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            mbr_r_q <= {BITS_DATA{1'b0}};
        end else begin
            mbr_r_q <= mbr_r_d;
        end
    end

    assign MBR_R     = mbr_r_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] mar;
    logic [31:0] mbr_w;
    logic        wr;
    logic        ordy;
    logic [31:0] mbr_r;
    logic [7:0]  out_data;
    logic        out_valid;

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    logic [7:0]  mq[$];
    logic [15:0] m_drops;
    logic        m_pw;
    logic [15:0] m_pm;
    logic [7:0]  m_last;
    logic [31:0] m_ram [int];
    logic [31:0] exp_mbr;
    bit          exp_known;

    always #5 clk = ~clk;

    mem_responder dut (
        .clk       (clk),
        .reset     (reset_n),
        .MAR       (mar),
        .MBR_W     (mbr_w),
        .write     (wr),
        .MBR_R     (mbr_r),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (ordy)
    );

    task automatic model_reset();
        mq.delete();
        m_drops   = 16'h0;
        m_pw      = 1'b0;
        m_pm      = 16'h0;
        m_last    = 8'h0;
        exp_mbr   = 32'h0;
        exp_known = 1'b1;
    endtask

    task automatic rd_model(input logic [15:0] a, output logic [31:0] v, output bit k);
        k = 1'b1;
        v = 32'h0;
        if (a < 16'd4096) begin
            if (m_ram.exists(int'(a))) v = m_ram[int'(a)];
            else k = 1'b0;
        end else if (a == 16'hFF01) begin
            v = {24'h0, 4'(mq.size()), 2'b00, (mq.size() == 0), (mq.size() == 8)};
        end else if (a == 16'hFF02) begin
            v = {16'h0, m_drops};
        end
    endtask

    task automatic model_edge();
        int  sz;
        bit  push, pop;
        sz   = mq.size();
        push = wr && (!m_pw || mar != m_pm) && (mar == 16'hFF00);
        pop  = (sz > 0) && ordy;
        if (wr && mar < 16'd4096) m_ram[int'(mar)] = mbr_w;
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (sz < 8 || pop) mq.push_back(mbr_w[7:0]);
            else if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
        end
        m_pw = wr;
        m_pm = mar;
        if (mq.size() > 0) m_last = mq[0];
    endtask

    // One clock: predict the falling-edge read, advance model at the rising edge.
    task automatic tick();
        logic [31:0] p;
        bit          pk;
        p  = 32'h0;
        pk = 1'b1;
        if (reset_n) rd_model(mar, p, pk);
        @(posedge clk);
        if (reset_n) model_edge();
        #1;
        exp_mbr   = p;
        exp_known = pk;
    endtask

    task automatic push_byte(input logic [7:0] b);
        mar   = 16'hFF00;
        mbr_w = {24'h0, b};
        wr    = 1'b1;
        tick();
        wr    = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        mar = 16'h0; mbr_w = 32'h0; wr = 1'b0; ordy = 1'b0;
        model_reset();
        repeat (2) tick();
        checks++; if (mbr_r !== 32'h0) begin failures++; $display("FAIL reset_mbr got=%h exp=%h", mbr_r, 32'h0); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 8'h0) begin failures++; $display("FAIL reset_data got=%h exp=00", out_data); end
        reset_n = 1'b1;
    endtask

    task automatic test_ram();
        mar = 16'd5; mbr_w = 32'hDEADBEEF; wr = 1'b1;
        tick();
        wr = 1'b0;
        tick();
        checks++; if (mbr_r !== 32'hDEADBEEF) begin failures++; $display("FAIL ram_rt got=%h exp=%h", mbr_r, 32'hDEADBEEF); end
        mar = 16'h8000;
        tick();
        checks++; if (mbr_r !== 32'h0) begin failures++; $display("FAIL unmapped got=%h exp=0", mbr_r); end
    endtask

    task automatic test_tx();
        logic [7:0] abc [3];
        abc = '{8'h41, 8'h42, 8'h43};
        ordy = 1'b0;
        for (int i = 0; i < 3; i++) push_byte(abc[i]);
        mar = 16'hFF01;
        tick();
        checks++; if (mbr_r !== 32'h30) begin failures++; $display("FAIL tx_status got=%h exp=%h", mbr_r, 32'h30); end
        ordy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== abc[i]) begin
                failures++; $display("FAIL tx_drain i=%0d got=%b/%h exp=1/%h", i, out_valid, out_data, abc[i]);
            end
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL tx_empty got=%b exp=0", out_valid); end
        ordy = 1'b0;
        tick();
        checks++; if (mbr_r !== 32'h2) begin failures++; $display("FAIL tx_status_empty got=%h exp=%h", mbr_r, 32'h2); end
        checks++; if (out_data !== 8'h43) begin failures++; $display("FAIL tx_hold got=%h exp=43", out_data); end
    endtask

    task automatic test_held();
        mar = 16'hFF00; mbr_w = 32'h41; wr = 1'b1;
        repeat (4) tick();
        wr = 1'b0; mar = 16'hFF01;
        tick();
        checks++; if (mbr_r !== 32'h10) begin failures++; $display("FAIL held_status got=%h exp=%h", mbr_r, 32'h10); end
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h41) begin failures++; $display("FAIL held_head got=%b/%h exp=1/41", out_valid, out_data); end
        ordy = 1'b1;
        tick();
        ordy = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL held_once got=%b exp=0", out_valid); end
    endtask

    task automatic test_overflow();
        ordy = 1'b0;
        for (int i = 0; i < 10; i++) push_byte(8'(8'h30 + i));
        mar = 16'hFF01;
        tick();
        checks++; if (mbr_r !== 32'h81) begin failures++; $display("FAIL ovf_status got=%h exp=%h", mbr_r, 32'h81); end
        mar = 16'hFF02;
        tick();
        checks++; if (mbr_r !== 32'h2) begin failures++; $display("FAIL ovf_drops got=%h exp=%h", mbr_r, 32'h2); end
        ordy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'(8'h30 + i)) begin
                failures++; $display("FAIL ovf_drain i=%0d got=%b/%h exp=1/%h", i, out_valid, out_data, 8'(8'h30 + i));
            end
            tick();
        end
        ordy = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ovf_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_full_pushpop();
        logic [7:0] e;
        ordy = 1'b0;
        for (int i = 0; i < 8; i++) push_byte(8'(8'h60 + i));
        mar = 16'hFF00; mbr_w = 32'h5A; wr = 1'b1; ordy = 1'b1;
        tick();
        wr = 1'b0; ordy = 1'b0; mar = 16'hFF01;
        tick();
        checks++; if (mbr_r !== 32'h81) begin failures++; $display("FAIL pp_status got=%h exp=%h", mbr_r, 32'h81); end
        mar = 16'hFF02;
        tick();
        checks++; if (mbr_r !== 32'h2) begin failures++; $display("FAIL pp_drops got=%h exp=%h", mbr_r, 32'h2); end
        ordy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            e = (i < 7) ? 8'(8'h61 + i) : 8'h5A;
            checks++;
            if (out_valid !== 1'b1 || out_data !== e) begin
                failures++; $display("FAIL pp_drain i=%0d got=%b/%h exp=1/%h", i, out_valid, out_data, e);
            end
            tick();
        end
        ordy = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL pp_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid();
        mar = 16'd7; mbr_w = 32'h12345678; wr = 1'b1;
        tick();
        wr = 1'b0;
        for (int i = 0; i < 5; i++) push_byte(8'(8'h70 + i));
        ordy = 1'b1;
        mar = 16'hFF01;
        tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rm_pre got=%b exp=1", out_valid); end
        reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rm_valid got=%b exp=0", out_valid); end
        checks++; if (mbr_r !== 32'h0) begin failures++; $display("FAIL rm_mbr got=%h exp=0", mbr_r); end
        model_reset();
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        checks++; if (mbr_r !== 32'h2 || out_valid !== 1'b0) begin failures++; $display("FAIL rm_status got=%h/%b exp=2/0", mbr_r, out_valid); end
        mar = 16'hFF02;
        tick();
        checks++; if (mbr_r !== 32'h0) begin failures++; $display("FAIL rm_drops got=%h exp=0", mbr_r); end
        mar = 16'd7;
        tick();
        checks++; if (mbr_r !== 32'h12345678) begin failures++; $display("FAIL rm_ram got=%h exp=12345678", mbr_r); end
        ordy = 1'b0;
    endtask

    task automatic test_random();
        int r;
        for (int a = 0; a < 16; a++) begin
            mar = 16'(a); mbr_w = $urandom; wr = 1'b1;
            tick();
        end
        wr = 1'b0;
        tick();
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3: mar = 16'($urandom_range(0, 15));
                4, 5:       mar = 16'hFF00;
                6:          mar = 16'hFF01;
                7:          mar = 16'hFF02;
                8:          mar = 16'h8000;
                default:    mar = 16'hFF03;
            endcase
            wr    = 1'($urandom_range(0, 1));
            mbr_w = $urandom;
            ordy  = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            tick();
            checks++;
            if (out_valid !== (mq.size() != 0)) begin
                failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, out_valid, (mq.size() != 0));
            end
            checks++;
            if (out_data !== m_last) begin
                failures++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", i, out_data, m_last);
            end
            if (exp_known) begin
                checks++;
                if (mbr_r !== exp_mbr) begin
                    failures++; $display("FAIL rnd_mbr cyc=%0d got=%h exp=%h", i, mbr_r, exp_mbr);
                end
            end
        end
        wr = 1'b0;
        ordy = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ram();
        test_tx();
        test_held();
        test_overflow();
        test_full_pushpop();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
